dmem_responder: RTL

Data-memory responder for the pipelined core: the memory-side end of the MEM-stage request interface (memReq, memWrite, memSize, address, write data). It accepts one request at a time, inserts a programmable number of wait states, performs byte/half/word reads and writes on a word-organised little-endian array, and returns right-justified read data with a one-cycle ready pulse. Sign extension of loads stays in the core; this block returns zero-extended data.

---
 rtl/dmem_responder_if.sv | 23 ++
 rtl/dmem_responder.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/dmem_responder_if.sv
// Request/response bundle between the MEM stage and the data-memory responder.
// Signal names match the core's existing MEM-stage port names.
interface dmem_responder_if;
    logic        i_memReq;
    logic        i_memWrite;
    logic [1:0]  i_memSize;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
    logic [31:0] o_rdata;
    logic        o_ready;
    logic        o_err;
    logic        o_busy;

    modport master (
        output i_memReq, i_memWrite, i_memSize, i_addr, i_wdata,
        input  o_rdata, o_ready, o_err, o_busy
    );

    modport slave (
        input  i_memReq, i_memWrite, i_memSize, i_addr, i_wdata,
        output o_rdata, o_ready, o_err, o_busy
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, programmable wait states,
// byte/half/word access on a little-endian word array, zero-extended loads.
module dmem_responder #(
    parameter int unsigned DEPTH       = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input logic             clk,
    input logic             reset_x,
    dmem_responder_if.slave bus
);
    localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StWait = 2'd1;
    localparam logic [1:0] StResp = 2'd2;

    logic [1:0]  stateQ, stateD;
    logic [3:0]  waitQ, waitD;
    logic        reqWriteQ;
    logic [1:0]  reqSizeQ;
    logic [31:0] reqAddrQ, reqWdataQ;
    logic [31:0] rdataQ, rdataD;
    logic        errQ;

    logic [31:0] mem [DEPTH];

    logic [31:0]     offset;
    logic [1:0]      lane;
    logic [IdxW-1:0] wordIdx;
    logic            accErr;
    logic            doAccess;
    logic            doWrite;
    logic [31:0]     rdWord;
    logic [31:0]     wrData;
    logic [3:0]      byteEn;

    assign offset   = reqAddrQ - BASE_ADDR;
    assign lane     = offset[1:0];
    assign wordIdx  = offset[IdxW+1:2];
    assign doAccess = (stateQ == StWait) && (waitQ == 4'd0);
    assign doWrite  = doAccess && reqWriteQ && !accErr;
    assign rdWord   = mem[wordIdx];

    always_comb begin
        accErr = 1'b0;
        case (reqSizeQ)
            2'b00:   accErr = 1'b0;
            2'b01:   accErr = lane[0];
            2'b10:   accErr = (lane != 2'b00);
            default: accErr = 1'b1;
        endcase
        // Address below the base wraps the offset; catch it before the range check.
        if (reqAddrQ < BASE_ADDR) accErr = 1'b1;
        if ({2'b00, offset[31:2]} >= 32'(DEPTH)) accErr = 1'b1;
    end

    // Store data is replicated across lanes so the byte enables alone pick the target.
    always_comb begin
        byteEn = 4'b0000;
        wrData = reqWdataQ;
        case (reqSizeQ)
            2'b00: begin
                byteEn = 4'b0001 << lane;
                wrData = {4{reqWdataQ[7:0]}};
            end
            2'b01: begin
                byteEn = lane[1] ? 4'b1100 : 4'b0011;
                wrData = {2{reqWdataQ[15:0]}};
            end
            default: byteEn = 4'b1111;
        endcase
    end

    always_comb begin
        rdataD = 32'h0;
        if (!accErr && !reqWriteQ) begin
            case (reqSizeQ)
                2'b00:   rdataD = {24'h0, rdWord[{lane, 3'b000} +: 8]};
                2'b01:   rdataD = {16'h0, rdWord[{lane[1], 4'b0000} +: 16]};
                default: rdataD = rdWord;
            endcase
        end
    end

    always_comb begin
        stateD = stateQ;
        waitD  = waitQ;
        case (stateQ)
            StIdle: begin
                if (bus.i_memReq) begin
                    stateD = StWait;
                    waitD  = 4'(WAIT_CYCLES);
                end
            end
            StWait: begin
                if (waitQ != 4'd0) begin
                    waitD = waitQ - 4'd1;
                end else begin
                    stateD = StResp;
                end
            end
            StResp:  stateD = StIdle;
            default: stateD = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset_x) begin
        if (reset_x) begin
            stateQ    <= StIdle;
            waitQ     <= 4'd0;
            reqWriteQ <= 1'b0;
            reqSizeQ  <= 2'b00;
            reqAddrQ  <= 32'h0;
            reqWdataQ <= 32'h0;
            rdataQ    <= 32'h0;
            errQ      <= 1'b0;
        end else begin
            stateQ <= stateD;
            waitQ  <= waitD;
            if (stateQ == StIdle && bus.i_memReq) begin
                reqWriteQ <= bus.i_memWrite;
                reqSizeQ  <= bus.i_memSize;
                reqAddrQ  <= bus.i_addr;
                reqWdataQ <= bus.i_wdata;
            end
            if (doAccess) begin
                rdataQ <= rdataD;
                errQ   <= accErr;
            end
        end
    end

    // Array is not reset; an asynchronous reset forces stateQ to idle, blocking doWrite.
    always_ff @(posedge clk) begin
        if (doWrite) begin
            for (int i = 0; i < 4; i++) begin
                if (byteEn[i]) mem[wordIdx][8*i +: 8] <= wrData[8*i +: 8];
            end
        end
    end

    assign bus.o_rdata = rdataQ;
    assign bus.o_err   = errQ;
    assign bus.o_ready = (stateQ == StResp);
    assign bus.o_busy  = (stateQ != StIdle);
endmodule
